// File: rtl/divider_pkg.sv
// Shared definitions for the divider family: FSM state encoding and
// iteration-counter sizing.
package divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // The counter must hold the value DATA_WIDTH itself, not just DATA_WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
// Handshake: a request is taken on a rising Clk edge where Ready && Start are
// both high. Ready is high only while the unit is idle and its result outputs are valid.
interface seq_divider_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] InputA;
    logic [DATA_WIDTH-1:0] InputB;
    logic                  Sign;
    logic                  Start;
    logic [DATA_WIDTH-1:0] Quotient;
    logic [DATA_WIDTH-1:0] Remainder;
    logic                  DivByZero;
    logic                  Ready;

    modport master (
        output InputA, InputB, Sign, Start,
        input  Quotient, Remainder, DivByZero, Ready
    );

    modport slave (
        input  InputA, InputB, Sign, Start,
        output Quotient, Remainder, DivByZero, Ready
    );
endinterface

// File: rtl/twos_negate.sv
// Combinational conditional two's-complement negate. The most-negative value
// maps to itself, which the divider reads as the unsigned magnitude 2^(W-1).
module twos_negate #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] out
);
    assign out = en ? ({DATA_WIDTH{1'b0}} - in) : in;
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on unsigned
// magnitudes, then a single sign-fix cycle before the result is published.
module seq_divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic         Clk,
    input  logic         nReset,
    seq_divider_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_width(DATA_WIDTH);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  divisor_q, dividend_q, rem_q;
    logic [W-1:0]  quot_q, rem_out_q;
    logic          negq_q, negr_q, zero_q, dbz_q;
    logic          ready, accept, run_step, fix_step;
    logic          a_neg, b_neg, zero_b;
    logic [W-1:0]  abs_a, abs_b, q_fixed, r_fixed;
    logic [W:0]    shifted, diff;

    assign a_neg  = bus.Sign & bus.InputA[W-1];
    assign b_neg  = bus.Sign & bus.InputB[W-1];
    assign zero_b = (bus.InputB == '0);

    twos_negate #(.DATA_WIDTH(W)) u_abs_a (.in(bus.InputA), .en(a_neg),  .out(abs_a));
    twos_negate #(.DATA_WIDTH(W)) u_abs_b (.in(bus.InputB), .en(b_neg),  .out(abs_b));
    twos_negate #(.DATA_WIDTH(W)) u_fix_q (.in(dividend_q), .en(negq_q), .out(q_fixed));
    twos_negate #(.DATA_WIDTH(W)) u_fix_r (.in(rem_q),      .en(negr_q), .out(r_fixed));

    // The restored remainder is always below the divisor, so W+1 bits are
    // enough to hold both the shifted value and the sign of the trial result.
    assign shifted = {rem_q, dividend_q[W-1]};
    assign diff    = shifted - {1'b0, divisor_q};

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.Start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        accept   = 1'b0;
        run_step = 1'b0;
        fix_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready  = 1'b1;
                accept = bus.Start;
            end
            ST_RUN:  run_step = 1'b1;
            ST_FIX:  fix_step = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            divisor_q  <= '0;
            dividend_q <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else if (accept) begin
            divisor_q  <= abs_b;
            dividend_q <= abs_a;
            rem_q      <= '0;
            cnt_q      <= CW'(W);
            // A zero divisor yields all-ones from the algorithm; only the
            // quotient negate would spoil that. Negating the remainder (|A|)
            // restores the dividend exactly as sampled.
            negq_q     <= (a_neg ^ b_neg) & ~zero_b;
            negr_q     <= a_neg;
            zero_q     <= zero_b;
        end else if (run_step) begin
            rem_q      <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
            dividend_q <= {dividend_q[W-2:0], ~diff[W]};
            cnt_q      <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            quot_q    <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else if (fix_step) begin
            quot_q    <= q_fixed;
            rem_out_q <= r_fixed;
            dbz_q     <= zero_q;
        end
    end

    assign bus.Ready     = ready;
    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_out_q;
    assign bus.DivByZero = dbz_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (DATA_WIDTH=16): results, latency,
// ignored mid-run requests, back-to-back requests and asynchronous reset.
module tb_seq_divider;
    localparam int W       = 16;
    localparam int LATENCY = W + 1;
    localparam int MAX_WAIT = 40;

    // Clock / reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    seq_divider_if #(.DATA_WIDTH(W)) bus ();

    seq_divider #(.DATA_WIDTH(W)) dut (
        .Clk      (clk),
        .nReset   (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // Scoreboard: {DivByZero, Remainder, Quotient}
    logic [2*W:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;
    int edges      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Driver: present a request at the falling edge, let it be accepted.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        @(negedge clk);
        check("ready_before_start", 32'(bus.Ready), 32'd1);
        bus.InputA = a;
        bus.InputB = b;
        bus.Sign   = s;
        bus.Start  = 1'b1;
        exp_q.push_back({ez, er, eq});
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        edges     = 0;
        check("ready_low_after_accept", 32'(bus.Ready), 32'd0);
    endtask

    task automatic finish_op(input string tag);
        logic [2*W:0] e;
        while (!bus.Ready && edges < MAX_WAIT) step();
        check({tag, "_latency"}, 32'(edges), 32'(LATENCY));
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_quotient"},  32'(bus.Quotient),  32'(e[W-1:0]));
            check({tag, "_remainder"}, 32'(bus.Remainder), 32'(e[2*W-1:W]));
            check({tag, "_divbyzero"}, 32'(bus.DivByZero), 32'(e[2*W]));
        end
    endtask

    initial begin
        bus.InputA = '0;
        bus.InputB = '0;
        bus.Sign   = 1'b0;
        bus.Start  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",     32'(bus.Ready),     32'd1);
        check("reset_quotient",  32'(bus.Quotient),  32'd0);
        check("reset_remainder", 32'(bus.Remainder), 32'd0);
        check("reset_divbyzero", 32'(bus.DivByZero), 32'd0);
        check("reset_state",     32'(dbg_state),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0);
        finish_op("u_100_7");
        start_op(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
        finish_op("s_m7_2");
        start_op(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0);
        finish_op("s_7_m2");
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0);
        finish_op("u_ffff_ffff");
        start_op(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0);
        finish_op("s_overflow");
        start_op(16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1);
        finish_op("u_div0");
        start_op(16'd1234, 16'd0, 1'b1, 16'hFFFF, 16'd1234, 1'b1);
        finish_op("s_div0");
        start_op(16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0);
        finish_op("u_clear_div0");

        // Request pulsed mid-run must be dropped; outputs hold the old result.
        start_op(16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0);
        repeat (5) step();
        check("midrun_hold_quotient", 32'(bus.Quotient), 32'd10);
        check("midrun_state_run",     32'(dbg_state),    32'd1);
        @(negedge clk);
        bus.InputA = 16'd9;
        bus.InputB = 16'd9;
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        finish_op("midrun_pulse");
        repeat (3) step();
        check("midrun_not_queued_ready", 32'(bus.Ready), 32'd1);
        check("midrun_not_queued_q",     32'(bus.Quotient), 32'd333);

        // Start held high across two operations.
        @(negedge clk);
        bus.InputA = 16'd200;
        bus.InputB = 16'd10;
        bus.Sign   = 1'b0;
        bus.Start  = 1'b1;
        exp_q.push_back({1'b0, 16'd0, 16'd20});
        exp_q.push_back({1'b0, 16'd5, 16'd9});
        @(posedge clk);
        #1;
        edges = 0;
        check("held_ready_low", 32'(bus.Ready), 32'd0);
        bus.InputA = 16'd77;
        bus.InputB = 16'd8;
        finish_op("held_first");
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        edges     = 0;
        check("held_second_accepted", 32'(bus.Ready), 32'd0);
        finish_op("held_second");

        // Asynchronous reset in the middle of a run.
        start_op(16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0);
        repeat (5) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_ready",     32'(bus.Ready),     32'd1);
        check("midreset_quotient",  32'(bus.Quotient),  32'd0);
        check("midreset_remainder", 32'(bus.Remainder), 32'd0);
        check("midreset_divbyzero", 32'(bus.DivByZero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'd9, 16'd2, 1'b0, 16'd4, 16'd1, 1'b0);
        finish_op("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
